fp32_arith_unit: RTL and testbench



---
 rtl/fp32_pkg.sv | 26 ++
 rtl/fp32_lzc.sv | 16 +
 rtl/fp32_arith_unit.sv | 222 ++++++++++++++++++++++
 tb/tb_fp32_arith_unit.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/fp32_pkg.sv
// Shared FP32 field widths, special encodings and the operand record type.
// Also holds the ordering key used by the optional FP32_CMP_EN compare outputs.
package fp32_pkg;

    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;
    localparam int BIAS   = 127;

    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam logic [31:0] POS_INF = 32'h7F80_0000;
    localparam logic [31:0] NEG_INF = 32'hFF80_0000;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } fp32_t;

    // Signed ordering key; denormals and both zeros collapse onto key 0
    function automatic logic signed [31:0] cmp_key(input fp32_t x);
        logic signed [31:0] mag;
        mag = $signed({1'b0, x.exp, x.frac});
        return (x.exp == 8'd0) ? 32'sd0 : (x.sign ? -mag : mag);
    endfunction

endpackage

// File: rtl/fp32_lzc.sv
// 24-bit leading-zero counter used to renormalise add/sub results.
// An all-zero input reports 24.
module fp32_lzc (
    input  logic [23:0] value,
    output logic [4:0]  count
);

    // Scan upward so the highest set bit is the last to overwrite the count
    always_comb begin
        count = 5'd24;
        for (int i = 0; i < 24; i++) begin
            count = value[i] ? 5'(23 - i) : count;
        end
    end

endmodule

// File: rtl/fp32_arith_unit.sv
// Single-cycle FP32 add/sub/mul with round-to-nearest-even and flush-to-zero.
// Optional macro FP32_CMP_EN adds registered lt/eq/gr compare flags.
module fp32_arith_unit
    import fp32_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        control,
    input  logic        mul,
    output logic        out_valid,
    output logic [31:0] result
`ifdef FP32_CMP_EN
    ,
    output logic        lt,
    output logic        eq,
    output logic        gr
`endif
);

    fp32_t       a_s, b_s;
    logic        a_zero_s, b_zero_s, a_inf_s, b_inf_s, a_nan_s, b_nan_s;
    logic [23:0] a_sig_s, b_sig_s;
    logic        b_sign_add_s;

    assign a_s          = fp32_t'(a);
    assign b_s          = fp32_t'(b);
    assign a_zero_s     = (a_s.exp == 8'd0);
    assign b_zero_s     = (b_s.exp == 8'd0);
    assign a_inf_s      = (a_s.exp == 8'hFF) && (a_s.frac == 23'd0);
    assign b_inf_s      = (b_s.exp == 8'hFF) && (b_s.frac == 23'd0);
    assign a_nan_s      = (a_s.exp == 8'hFF) && (a_s.frac != 23'd0);
    assign b_nan_s      = (b_s.exp == 8'hFF) && (b_s.frac != 23'd0);
    assign a_sig_s      = a_zero_s ? 24'd0 : {1'b1, a_s.frac};
    assign b_sig_s      = b_zero_s ? 24'd0 : {1'b1, b_s.frac};
    assign b_sign_add_s = b_s.sign ^ control;

    logic              add_swap_s, add_xs_s, add_ys_s;
    logic [7:0]        add_ex_s, add_diff_s;
    logic [23:0]       add_sx_s, add_sy_s;
    logic [4:0]        add_shamt_s, add_lz_s;
    logic [53:0]       add_shift_s;
    logic [26:0]       add_align_s, add_norm_s;
    logic [27:0]       add_sum_s;
    logic [23:0]       add_mant_s;
    logic              add_g_s, add_st_s, add_sign_s, add_zero_s;
    logic signed [9:0] add_e_s;

    // Order operands by magnitude, align the smaller one with sticky, then add or subtract
    always_comb begin
        add_swap_s = {b_s.exp, b_sig_s} > {a_s.exp, a_sig_s};
        if (add_swap_s) begin
            add_ex_s   = b_s.exp;
            add_sx_s   = b_sig_s;
            add_xs_s   = b_sign_add_s;
            add_sy_s   = a_sig_s;
            add_ys_s   = a_s.sign;
            add_diff_s = b_s.exp - a_s.exp;
        end else begin
            add_ex_s   = a_s.exp;
            add_sx_s   = a_sig_s;
            add_xs_s   = a_s.sign;
            add_sy_s   = b_sig_s;
            add_ys_s   = b_sign_add_s;
            add_diff_s = a_s.exp - b_s.exp;
        end
        // Shifts past 27 only feed sticky, so cap the distance there
        add_shamt_s = (add_diff_s > 8'd27) ? 5'd27 : add_diff_s[4:0];
        add_shift_s = {add_sy_s, 30'd0} >> add_shamt_s;
        add_align_s = {add_shift_s[53:28], add_shift_s[27] | (|add_shift_s[26:0])};
        if (add_xs_s == add_ys_s) begin
            add_sum_s = {1'b0, add_sx_s, 3'b000} + {1'b0, add_align_s};
        end else begin
            add_sum_s = {1'b0, add_sx_s, 3'b000} - {1'b0, add_align_s};
        end
    end

    fp32_lzc u_lzc (
        .value (add_sum_s[26:3]),
        .count (add_lz_s)
    );

    // Renormalise the add/sub sum: one-bit right shift on carry, else left by the zero count
    always_comb begin
        add_zero_s = (add_sum_s == 28'd0);
        add_norm_s = add_sum_s[26:0] << add_lz_s;
        if (add_sum_s[27]) begin
            add_mant_s = add_sum_s[27:4];
            add_g_s    = add_sum_s[3];
            add_st_s   = |add_sum_s[2:0];
            add_e_s    = $signed({2'b00, add_ex_s}) + 10'sd1;
        end else begin
            add_mant_s = add_norm_s[26:3];
            add_g_s    = add_norm_s[2];
            add_st_s   = |add_norm_s[1:0];
            add_e_s    = $signed({2'b00, add_ex_s}) - $signed({5'd0, add_lz_s});
        end
        add_sign_s = add_zero_s ? (add_xs_s & add_ys_s) : add_xs_s;
    end

    logic [47:0]       mul_prod_s;
    logic [23:0]       mul_mant_s;
    logic              mul_g_s, mul_st_s, mul_sign_s, mul_zero_s;
    logic signed [9:0] mul_e_s;

    // Significand product with a single normalising step
    always_comb begin
        mul_prod_s = a_sig_s * b_sig_s;
        mul_zero_s = a_zero_s | b_zero_s;
        mul_sign_s = a_s.sign ^ b_s.sign;
        mul_e_s    = $signed({2'b00, a_s.exp}) + $signed({2'b00, b_s.exp}) - $signed(10'(BIAS));
        if (mul_prod_s[47]) begin
            mul_mant_s = mul_prod_s[47:24];
            mul_g_s    = mul_prod_s[23];
            mul_st_s   = |mul_prod_s[22:0];
            mul_e_s    = mul_e_s + 10'sd1;
        end else begin
            mul_mant_s = mul_prod_s[46:23];
            mul_g_s    = mul_prod_s[22];
            mul_st_s   = |mul_prod_s[21:0];
        end
    end

    logic [23:0]       sel_mant_s;
    logic              sel_g_s, sel_st_s, sel_sign_s, sel_zero_s, rnd_up_s;
    logic signed [9:0] sel_e_s, rnd_e_s;
    logic [24:0]       rnd_mant_s;
    logic [22:0]       rnd_frac_s;

    // Select the active path and round to nearest, ties to even
    always_comb begin
        if (mul) begin
            sel_mant_s = mul_mant_s;
            sel_g_s    = mul_g_s;
            sel_st_s   = mul_st_s;
            sel_e_s    = mul_e_s;
            sel_sign_s = mul_sign_s;
            sel_zero_s = mul_zero_s;
        end else begin
            sel_mant_s = add_mant_s;
            sel_g_s    = add_g_s;
            sel_st_s   = add_st_s;
            sel_e_s    = add_e_s;
            sel_sign_s = add_sign_s;
            sel_zero_s = add_zero_s;
        end
        rnd_up_s   = sel_g_s & (sel_st_s | sel_mant_s[0]);
        rnd_mant_s = {1'b0, sel_mant_s} + {24'd0, rnd_up_s};
        if (rnd_mant_s[24]) begin
            rnd_e_s    = sel_e_s + 10'sd1;
            rnd_frac_s = rnd_mant_s[23:1];
        end else begin
            rnd_e_s    = sel_e_s;
            rnd_frac_s = rnd_mant_s[22:0];
        end
    end

    logic        nan_s, inf_s, inf_sign_s;
    logic [31:0] res_next_s;

    // Special operands take priority, then zero/underflow, overflow and the normal pack
    always_comb begin
        if (mul) begin
            nan_s      = a_nan_s | b_nan_s | (a_inf_s & b_zero_s) | (b_inf_s & a_zero_s);
            inf_s      = a_inf_s | b_inf_s;
            inf_sign_s = mul_sign_s;
        end else begin
            nan_s      = a_nan_s | b_nan_s | (a_inf_s & b_inf_s & (a_s.sign != b_sign_add_s));
            inf_s      = a_inf_s | b_inf_s;
            inf_sign_s = a_inf_s ? a_s.sign : b_sign_add_s;
        end
        if (nan_s) begin
            res_next_s = QNAN;
        end else if (inf_s) begin
            res_next_s = inf_sign_s ? NEG_INF : POS_INF;
        end else if (sel_zero_s || (rnd_e_s <= 10'sd0)) begin
            res_next_s = {sel_sign_s, 31'd0};
        end else if (rnd_e_s >= 10'sd255) begin
            res_next_s = sel_sign_s ? NEG_INF : POS_INF;
        end else begin
            res_next_s = {sel_sign_s, rnd_e_s[7:0], rnd_frac_s};
        end
    end

`ifdef FP32_CMP_EN
    logic signed [31:0] key_a_s, key_b_s;
    logic               cmp_nan_s;

    // Ordering keys for the compare flags
    always_comb begin
        key_a_s   = cmp_key(a_s);
        key_b_s   = cmp_key(b_s);
        cmp_nan_s = a_nan_s | b_nan_s;
    end
`endif

    // Output stage: result and flags load under in_valid, valid tracks in_valid
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result    <= 32'h0000_0000;
            out_valid <= 1'b0;
`ifdef FP32_CMP_EN
            lt        <= 1'b0;
            eq        <= 1'b0;
            gr        <= 1'b0;
`endif
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                result <= res_next_s;
`ifdef FP32_CMP_EN
                lt     <= ~cmp_nan_s & (key_a_s < key_b_s);
                eq     <= ~cmp_nan_s & (key_a_s == key_b_s);
                gr     <= ~cmp_nan_s & (key_a_s > key_b_s);
`endif
            end
        end
    end

endmodule

// File: tb/tb_fp32_arith_unit.sv
// Self-checking bench for fp32_arith_unit: directed vector table, reset/streaming
// sequences and randomized ops checked against a real-arithmetic reference model.
module tb_fp32_arith_unit;

    logic        clk = 1'b0;
    logic        rst, in_valid, control, mul;
    logic [31:0] a, b, result;
    logic        out_valid;
`ifdef FP32_CMP_EN
    logic        lt, eq, gr;
`endif

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] model_res;

    fp32_arith_unit dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .control   (control),
        .mul       (mul),
        .out_valid (out_valid),
        .result    (result)
`ifdef FP32_CMP_EN
        ,
        .lt        (lt),
        .eq        (eq),
        .gr        (gr)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, got, expv);
        end
    endtask

    // Exact value of a flushed FP32 operand as a double (zeros return 0.0)
    function automatic real to_real(input logic [31:0] x);
        int  e;
        real m;
        e = int'(x[30:23]);
        if (e == 0) return 0.0;
        m = (1.0 + real'(x[22:0]) / 8388608.0) * (2.0 ** (e - 127));
        return x[31] ? -m : m;
    endfunction

    // Round a double to FP32 nearest-even; tiny results flush, huge ones saturate to inf
    function automatic logic [31:0] from_real(input real r, input logic zsign);
        logic [63:0] d;
        logic [52:0] m;
        logic [24:0] keep;
        int          e;
        if (r == 0.0) return {zsign, 31'd0};
        d    = $realtobits(r);
        e    = int'(d[62:52]) - 1023 + 127;
        m    = {1'b1, d[51:0]};
        keep = {1'b0, m[52:29]};
        if (m[28] && ((|m[27:0]) || keep[0])) keep = keep + 25'd1;
        if (keep[24]) begin
            e    = e + 1;
            keep = keep >> 1;
        end
        if (e >= 255) return {d[63], 8'hFF, 23'd0};
        if (e <= 0) return {d[63], 31'd0};
        return {d[63], e[7:0], keep[22:0]};
    endfunction

    // Double-precision products/sums of FP32 values round innocuously back to FP32
    function automatic logic [31:0] ref_model(input logic [31:0] x, input logic [31:0] y,
                                              input logic c, input logic m);
        logic x_nan, y_nan, x_inf, y_inf, x_zero, y_zero, yse;
        x_nan  = (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
        y_nan  = (y[30:23] == 8'hFF) && (y[22:0] != 23'd0);
        x_inf  = (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
        y_inf  = (y[30:23] == 8'hFF) && (y[22:0] == 23'd0);
        x_zero = (x[30:23] == 8'd0);
        y_zero = (y[30:23] == 8'd0);
        if (x_nan || y_nan) return 32'h7FC0_0000;
        if (m) begin
            if ((x_inf && y_zero) || (y_inf && x_zero)) return 32'h7FC0_0000;
            if (x_inf || y_inf) return {x[31] ^ y[31], 8'hFF, 23'd0};
            return from_real(to_real(x) * to_real(y), x[31] ^ y[31]);
        end
        yse = y[31] ^ c;
        if (x_inf && y_inf) return (x[31] == yse) ? {x[31], 8'hFF, 23'd0} : 32'h7FC0_0000;
        if (x_inf) return {x[31], 8'hFF, 23'd0};
        if (y_inf) return {yse, 8'hFF, 23'd0};
        return from_real(to_real(x) + (c ? -to_real(y) : to_real(y)), x[31] & yse);
    endfunction

    function automatic logic [31:0] rand_fp(input int near);
        logic [31:0] v;
        int          k, e;
        v = $urandom;
        k = int'($urandom_range(0, 19));
        if (k == 0) begin
            e = 0;
        end else if (k == 1) begin
            e = 255;
            if ($urandom_range(0, 1) == 0) v[22:0] = 23'd0;
        end else if (k < 12) begin
            e = near + int'($urandom_range(0, 60)) - 30;
        end else begin
            e = int'($urandom_range(1, 254));
        end
        if (k > 1 && e < 1) e = 1;
        if (k > 1 && e > 254) e = 254;
        v[30:23] = e[7:0];
        return v;
    endfunction

    task automatic run_op(input string name, input logic [31:0] x, input logic [31:0] y,
                          input logic c, input logic m, input logic [31:0] expv);
        @(negedge clk);
        a = x; b = y; control = c; mul = m; in_valid = 1'b1;
        @(posedge clk);
        #1;
        check({name, "_valid"}, {31'd0, out_valid}, 32'd1);
        check(name, result, expv);
        model_res = expv;
    endtask

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic        c;
        logic        m;
        logic [31:0] expv;
    } vec_t;

    vec_t tbl[$];

    initial begin
        tbl.push_back('{"add_1_2",       32'h3F80_0000, 32'h4000_0000, 1'b0, 1'b0, 32'h4040_0000});
        tbl.push_back('{"sub_1_1",       32'h3F80_0000, 32'h3F80_0000, 1'b1, 1'b0, 32'h0000_0000});
        tbl.push_back('{"mul_3_mhalf",   32'h4040_0000, 32'hBF00_0000, 1'b1, 1'b1, 32'hBFC0_0000});
        tbl.push_back('{"tie_even_down", 32'h3F80_0000, 32'h3380_0000, 1'b0, 1'b0, 32'h3F80_0000});
        tbl.push_back('{"tie_even_up",   32'h3F80_0001, 32'h3380_0000, 1'b0, 1'b0, 32'h3F80_0002});
        tbl.push_back('{"add_overflow",  32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 1'b0, 32'h7F80_0000});
        tbl.push_back('{"inf_sub_inf",   32'h7F80_0000, 32'h7F80_0000, 1'b1, 1'b0, 32'h7FC0_0000});
        tbl.push_back('{"nan_in",        32'h7F80_0001, 32'h3F80_0000, 1'b0, 1'b0, 32'h7FC0_0000});
        tbl.push_back('{"zero_x_inf",    32'h0000_0000, 32'h7F80_0000, 1'b0, 1'b1, 32'h7FC0_0000});
        tbl.push_back('{"ninf_plus_1",   32'hFF80_0000, 32'h3F80_0000, 1'b0, 1'b0, 32'hFF80_0000});
        tbl.push_back('{"nzero_nzero",   32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h8000_0000});
        tbl.push_back('{"nzero_sub_z",   32'h8000_0000, 32'h0000_0000, 1'b1, 1'b0, 32'h8000_0000});
        tbl.push_back('{"denorm_add",    32'h0000_0001, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000});
        tbl.push_back('{"denorm_mul",    32'h807F_FFFF, 32'h3F80_0000, 1'b0, 1'b1, 32'h8000_0000});
        tbl.push_back('{"mul_underflow", 32'h0080_0000, 32'h3F00_0000, 1'b0, 1'b1, 32'h0000_0000});
        tbl.push_back('{"inf_x_m2",      32'h7F80_0000, 32'hC000_0000, 1'b0, 1'b1, 32'hFF80_0000});
        tbl.push_back('{"mul_overflow",  32'h7F00_0000, 32'h4000_0000, 1'b0, 1'b1, 32'h7F80_0000});
        tbl.push_back('{"cancel_lzc",    32'h3F80_0000, 32'h3F7F_FFFF, 1'b1, 1'b0, 32'h3380_0000});
        tbl.push_back('{"m2_plus_half",  32'hC000_0000, 32'h3F00_0000, 1'b0, 1'b0, 32'hBFC0_0000});
        tbl.push_back('{"mul_round",     32'h3F80_0001, 32'h3F80_0001, 1'b0, 1'b1, 32'h3F80_0002});

        rst = 1'b1; in_valid = 1'b0; control = 1'b0; mul = 1'b0;
        a = 32'h0; b = 32'h0;
        model_res = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_result", result, 32'h0);
        check("reset_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        foreach (tbl[i]) run_op(tbl[i].name, tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].m, tbl[i].expv);

        // Toggling control mid-cycle must not disturb a multiply
        @(negedge clk);
        a = 32'h4040_0000; b = 32'hBF00_0000; mul = 1'b1; control = 1'b0; in_valid = 1'b1;
        #2 control = 1'b1;
        @(posedge clk);
        #1;
        check("mul_ctrl_toggle", result, 32'hBFC0_0000);
        model_res = 32'hBFC0_0000;

        // Idle cycle holds the result and drops valid
        @(negedge clk);
        in_valid = 1'b0; a = 32'h4120_0000; b = 32'h4120_0000; mul = 1'b0;
        @(posedge clk);
        #1;
        check("idle_valid", {31'd0, out_valid}, 32'd0);
        check("idle_hold", result, model_res);

        // Reset asserted between edges while an op is pending
        run_op("pre_reset", 32'h3F80_0000, 32'h4000_0000, 1'b0, 1'b0, 32'h4040_0000);
        a = 32'h4000_0000; b = 32'h4000_0000;
        #2 rst = 1'b1;
        #1;
        check("midrst_result", result, 32'h0);
        check("midrst_valid", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #1;
        check("rst_held_result", result, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        model_res = 32'h0;
        run_op("b2b_add", 32'h4000_0000, 32'h4000_0000, 1'b0, 1'b0, 32'h4080_0000);
        run_op("b2b_mul", 32'h4040_0000, 32'h4040_0000, 1'b0, 1'b1, 32'h4110_0000);
        run_op("b2b_sub", 32'h40A0_0000, 32'h3F00_0000, 1'b1, 1'b0, 32'h4090_0000);

        // Randomized stream with gaps, checked against the reference model
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            in_valid = ($urandom_range(0, 7) != 0);
            a        = rand_fp(int'($urandom_range(1, 254)));
            if ($urandom_range(0, 9) == 0) b = a ^ 32'h8000_0000;
            else b = rand_fp(int'(a[30:23]));
            control  = 1'($urandom_range(0, 1));
            mul      = ($urandom_range(0, 2) == 0);
            if (in_valid) model_res = ref_model(a, b, control, mul);
            @(posedge clk);
            #1;
            check("rand_valid", {31'd0, out_valid}, {31'd0, in_valid});
            if (result !== model_res)
                $display("  a=%08h b=%08h control=%0b mul=%0b", a, b, control, mul);
            check("rand_result", result, model_res);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
